// File: rtl/asip_mem_arb_pkg.sv
// Shared types for the data-memory arbiter: grant encoding and memory word type.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: grant_e (which requester drives the memory), vec_t (one memory word at the default geometry).
package asip_mem_arb_pkg;

  localparam int VEC_SIZE = 4;  // lanes per memory word
  localparam int REG_SIZE = 8;  // bits per lane, also the address width

  typedef enum logic {
    GNT_PIPE = 1'b0,
    GNT_HOST = 1'b1
  } grant_e;

  typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] vec_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating refusal counter: clear wins over increment, holds at MAX_CNT, flags when saturated.
// Latency: at_max_o reflects the registered count (value for the current cycle).
// Backpressure: none; counts whatever the caller reports each cycle.
// Ports: clk, reset (sync, active-high), clr_i, inc_i, at_max_o.
module arb_wait_counter #(
  parameter int MAX_CNT = 4,
  parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline (priority) and a host port.
// Latency: memory grant/control is combinational; host read data returns one cycle after acceptance.
// Backpressure: pipeline is stalled when the host is granted; host waits on host_ready, forced after maxWait refusals.
// Ports: pipe_* (stallable pipeline access), host_* (valid/ready host access + registered read response),
//        mem_* (single-port memory, combinational read).
module data_mem_arbiter
  import asip_mem_arb_pkg::*;
#(
  parameter int vecSize      = 4,
  parameter int registerSize = 8,
  parameter int maxWait      = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   pipe_req,
  input  logic                                   pipe_we,
  input  logic [registerSize-1:0]                pipe_addr,
  input  logic [vecSize-1:0][registerSize-1:0]   pipe_wdata,
  output logic [vecSize-1:0][registerSize-1:0]   pipe_rdata,
  output logic                                   pipe_stall,
  input  logic                                   host_valid,
  input  logic                                   host_we,
  input  logic [registerSize-1:0]                host_addr,
  input  logic [vecSize-1:0][registerSize-1:0]   host_wdata,
  output logic                                   host_ready,
  output logic                                   host_rvalid,
  output logic [vecSize-1:0][registerSize-1:0]   host_rdata,
  output logic                                   mem_we,
  output logic [registerSize-1:0]                mem_addr,
  output logic [vecSize-1:0][registerSize-1:0]   mem_wdata,
  input  logic [vecSize-1:0][registerSize-1:0]   mem_rdata
);

  grant_e grant;
  logic   wait_at_max;
  logic   host_acc;

  // Host wins when the pipeline is idle, or when it has been refused maxWait
  // times in a row; the pipeline keeps priority otherwise.
  always_comb begin
    grant = GNT_PIPE;
    if (!reset && host_valid && (!pipe_req || wait_at_max)) begin
      grant = GNT_HOST;
    end
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = pipe_addr;
    mem_wdata  = pipe_wdata;
    host_ready = 1'b0;
    pipe_stall = 1'b0;
    if (grant == GNT_HOST) begin
      mem_we     = host_we;
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
      host_ready = 1'b1;
      pipe_stall = pipe_req;
    end else if (!reset) begin
      mem_we = pipe_req & pipe_we;
    end
  end

  assign pipe_rdata = mem_rdata;
  assign host_acc   = host_valid & host_ready;

  // Refusals only accumulate while the host keeps asking; acceptance or a
  // withdrawn request restarts the count.
  arb_wait_counter #(
    .MAX_CNT (maxWait)
  ) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (!host_valid || host_acc),
    .inc_i    (host_valid && !host_acc),
    .at_max_o (wait_at_max)
  );

  logic                                 rvalid_q, rvalid_d;
  logic [vecSize-1:0][registerSize-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = host_acc & ~host_we;
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // A response registered just before reset is raised must not leak out
  // during the reset cycle itself.
  assign host_rvalid = rvalid_q & ~reset;
  assign host_rdata  = rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_req, pipe_we;
  logic [7:0]  pipe_addr;
  logic [31:0] pipe_wdata, pipe_rdata;
  logic        pipe_stall;
  logic        host_valid, host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ready, host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.vecSize(4), .registerSize(8), .maxWait(MAXW)) dut (
    .clk(clk), .reset(reset),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory instance the arbiter drives: combinational read, write on the edge.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: refusal count, pending response and a shadow of memory.
  int          m_cnt = 0;
  bit          m_rv = 0;
  logic [31:0] m_rdata = '0;
  logic [31:0] shadow [0:255];
  bit          m_acc = 0;
  initial for (int i = 0; i < 256; i++) shadow[i] = '0;

  always @(negedge clk) begin
    bit          gh, ewe;
    logic [7:0]  eaddr;
    logic [31:0] ewd;
    gh    = !reset && host_valid && (!pipe_req || m_cnt == MAXW);
    ewe   = reset ? 1'b0 : (gh ? host_we : (pipe_req && pipe_we));
    eaddr = gh ? host_addr : pipe_addr;
    ewd   = gh ? host_wdata : pipe_wdata;
    check("host_ready", 64'(host_ready), 64'(gh));
    check("pipe_stall", 64'(pipe_stall), 64'(gh && pipe_req));
    check("mem_we", 64'(mem_we), 64'(ewe));
    check("mem_addr", 64'(mem_addr), 64'(eaddr));
    check("mem_wdata", 64'(mem_wdata), 64'(ewd));
    check("host_rvalid", 64'(host_rvalid), 64'(m_rv && !reset));
    check("host_rdata", 64'(host_rdata), 64'(m_rdata));
    if (pipe_req && !(gh && pipe_req))
      check("pipe_rdata", 64'(pipe_rdata), 64'(shadow[pipe_addr]));
    m_acc = gh;
    if (reset) begin
      m_cnt = 0; m_rv = 0; m_rdata = '0;
    end else begin
      m_rv = gh && !host_we;
      if (m_rv) m_rdata = shadow[host_addr];
      if (!host_valid || gh) m_cnt = 0;
      else if (m_cnt < MAXW) m_cnt = m_cnt + 1;
    end
    if (ewe) shadow[eaddr] = ewd;
  end

  task automatic drv(input bit rst, input bit preq, input bit pwe, input logic [7:0] pa,
                     input logic [31:0] pwd, input bit hv, input bit hwe,
                     input logic [7:0] ha, input logic [31:0] hwd);
    @(posedge clk); #1;
    reset = rst; pipe_req = preq; pipe_we = pwe; pipe_addr = pa; pipe_wdata = pwd;
    host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hwd;
    #2;
  endtask

  task automatic idle();
    drv(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
  endtask

  initial begin
    logic [9:0] rdy_pat, stl_pat;
    logic [4:0] pat5;
    reset = 1; pipe_req = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
    host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;

    // Reset with both sides trying to write.
    drv(1, 1, 1, 8'h33, 32'hAAAAAAAA, 1, 1, 8'h44, 32'h55555555);
    drv(1, 1, 1, 8'h33, 32'hAAAAAAAA, 1, 1, 8'h44, 32'h55555555);
    check("rst_host_ready", 64'(host_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_pipe_stall", 64'(pipe_stall), 64'd0);
    check("rst_rvalid", 64'(host_rvalid), 64'd0);
    check("rst_rdata", 64'(host_rdata), 64'd0);

    // Host only: write then read back 0x10.
    drv(0, 0, 0, 8'h00, 32'h0, 1, 1, 8'h10, 32'h01020304);
    check("h_wr_ready", 64'(host_ready), 64'd1);
    drv(0, 0, 0, 8'h00, 32'h0, 1, 0, 8'h10, 32'h0);
    check("h_rd_ready", 64'(host_ready), 64'd1);
    check("h_rd_rvalid_after_wr", 64'(host_rvalid), 64'd0);
    idle();
    check("h_rvalid", 64'(host_rvalid), 64'd1);
    check("h_rdata", 64'(host_rdata), 64'h01020304);

    // Pipe only: write then read 0x05.
    drv(0, 1, 1, 8'h05, 32'h09090909, 0, 0, 8'h00, 32'h0);
    check("p_wr_stall", 64'(pipe_stall), 64'd0);
    drv(0, 1, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0);
    check("p_rd_stall", 64'(pipe_stall), 64'd0);
    check("p_rdata", 64'(pipe_rdata), 64'h09090909);
    check("p_rvalid", 64'(host_rvalid), 64'd0);

    // Continuous contention: host granted on every 5th cycle.
    idle();
    for (int i = 0; i < 10; i++) begin
      drv(0, 1, 0, 8'h00, 32'h0, 1, 0, 8'h01, 32'h0);
      rdy_pat[i] = host_ready;
      stl_pat[i] = pipe_stall;
    end
    check("cont_ready_pat", 64'(rdy_pat), 64'h210);
    check("cont_stall_pat", 64'(stl_pat), 64'h210);

    // Withdraw after 2 refusals; count restarts on re-request.
    idle();
    drv(0, 1, 0, 8'h00, 32'h0, 1, 0, 8'h01, 32'h0);
    pat5[0] = host_ready;
    drv(0, 1, 0, 8'h00, 32'h0, 1, 0, 8'h01, 32'h0);
    pat5[1] = host_ready;
    check("wd_refused", 64'(pat5[1:0]), 64'd0);
    drv(0, 1, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 0, 8'h00, 32'h0, 1, 0, 8'h01, 32'h0);
      pat5[i] = host_ready;
    end
    check("wd_ready_pat", 64'(pat5), 64'h10);

    // Back-to-back host reads.
    drv(0, 0, 0, 8'h00, 32'h0, 1, 1, 8'h01, 32'h01010101);
    drv(0, 0, 0, 8'h00, 32'h0, 1, 1, 8'h02, 32'h02020202);
    drv(0, 0, 0, 8'h00, 32'h0, 1, 0, 8'h01, 32'h0);
    drv(0, 0, 0, 8'h00, 32'h0, 1, 0, 8'h02, 32'h0);
    check("b2b_rv1", 64'(host_rvalid), 64'd1);
    check("b2b_rd1", 64'(host_rdata), 64'h01010101);
    idle();
    check("b2b_rv2", 64'(host_rvalid), 64'd1);
    check("b2b_rd2", 64'(host_rdata), 64'h02020202);
    idle();
    check("b2b_rv_end", 64'(host_rvalid), 64'd0);

    // Reset the cycle after an accepted read.
    drv(0, 0, 0, 8'h00, 32'h0, 1, 0, 8'h02, 32'h0);
    drv(1, 1, 1, 8'h07, 32'hDEADBEEF, 1, 0, 8'h02, 32'h0);
    check("mr_rvalid", 64'(host_rvalid), 64'd0);
    check("mr_mem_we", 64'(mem_we), 64'd0);
    check("mr_ready", 64'(host_ready), 64'd0);
    check("mr_stall", 64'(pipe_stall), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 0, 8'h00, 32'h0, 1, 0, 8'h02, 32'h0);
      pat5[i] = host_ready;
    end
    check("mr_ready_pat", 64'(pat5), 64'h10);
    idle();

    // Randomized traffic against the model; host holds a request until accepted.
    for (int i = 0; i < 3000; i++) begin
      bit          hold, r, pr, pw, hv, hw;
      logic [7:0]  pa, ha;
      logic [31:0] pd, hd;
      hold = host_valid && !m_acc;
      r  = ($urandom_range(0, 149) == 0);
      pr = ($urandom_range(0, 9) < 7);
      pw = $urandom_range(0, 1) == 1;
      pa = 8'($urandom_range(0, 15));
      pd = $urandom;
      if (hold) begin
        hv = 1; hw = host_we; ha = host_addr; hd = host_wdata;
      end else begin
        hv = $urandom_range(0, 1) == 1;
        hw = $urandom_range(0, 1) == 1;
        ha = 8'($urandom_range(0, 15));
        hd = $urandom;
      end
      drv(r, pr, pw, pa, pd, hv, hw, ha, hd);
    end
    idle();
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
